// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants.
package pipe_ctrl_pkg;

  // Sequencer states; 2-bit encoding shared with anything that decodes them.
  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StFlush  = 2'b01,
    StHalted = 2'b10,
    StStep   = 2'b11
  } ctrl_state_e;

  // addi x0, x0, 0 -- loaded into if_id on a flush.
  localparam logic [31:0] InstNop = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges ex jump/hold, fetch-bus wait and debug halt/step
// into PC redirect and per-stage hold/flush controls.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_ex_i,
  input  logic              hold_bus_i,
  input  logic              halt_req_i,
  input  logic              step_i,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              pc_hold_o,
  output logic              if_id_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_hold_o,
  output logic              id_ex_flush_o,
  output logic              halt_ack_o
);
  import pipe_ctrl_pkg::*;

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(FLUSH_CYCLES - 1);
  // With a single bubble cycle the jump cycle itself is the whole flush.
  localparam bit MultiFlush = (FLUSH_CYCLES > 1);

  ctrl_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            halt_ack_q, halt_ack_d;

  assign jump_addr_o = jump_addr_i;
  assign halt_ack_o  = halt_ack_q;

  // State, flush counter and halt acknowledge registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      halt_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halt_ack_q <= halt_ack_d;
    end
  end

  // Next-state and output decode; flush and hold of a register are exclusive per branch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    jump_en_o     = 1'b0;
    pc_hold_o     = 1'b0;
    if_id_hold_o  = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_hold_o  = 1'b0;
    id_ex_flush_o = 1'b0;

    if (rst) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      state_d       = StRun;
      cnt_d         = '0;
    end else begin
      unique case (state_q)
        StRun, StStep: begin
          if (hold_ex_i) begin
            // Stall everything; a concurrent jump is replayed once hold drops.
            pc_hold_o    = 1'b1;
            if_id_hold_o = 1'b1;
            id_ex_hold_o = 1'b1;
          end else if (jump_en_i) begin
            jump_en_o     = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            if (MultiFlush) begin
              state_d = StFlush;
              cnt_d   = CntInit;
            end else if (state_q == StStep) begin
              state_d = StHalted;
            end else begin
              state_d = StRun;
            end
          end else begin
            if (hold_bus_i) begin
              pc_hold_o     = 1'b1;
              if_id_flush_o = 1'b1;
            end
            if (state_q == StStep || halt_req_i) begin
              state_d = StHalted;
            end
          end
        end
        StFlush: begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          cnt_d         = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_d = halt_req_i ? StHalted : StRun;
          end
        end
        StHalted: begin
          pc_hold_o    = 1'b1;
          if_id_hold_o = 1'b1;
          id_ex_hold_o = 1'b1;
          if (!halt_req_i) begin
            state_d = StRun;
          end else if (step_i) begin
            state_d = StStep;
          end
        end
        default: state_d = StRun;
      endcase
    end

    halt_ack_d = (state_d == StHalted);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (FLUSH_CYCLES=2 and 3) share stimulus;
// expected output vectors are queued at drive time and checked at the falling edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_ex_i = 1'b0;
  logic        hold_bus_i = 1'b0;
  logic        halt_req_i = 1'b0;
  logic        step_i = 1'b0;

  logic        je2, ph2, ih2, if2, eh2, ef2, ha2;
  logic        je3, ph3, ih3, if3, eh3, ef3, ha3;
  logic [31:0] ja2, ja3;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .ADDR_W(32)) dut2 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i), .halt_req_i(halt_req_i), .step_i(step_i),
    .jump_en_o(je2), .jump_addr_o(ja2), .pc_hold_o(ph2), .if_id_hold_o(ih2),
    .if_id_flush_o(if2), .id_ex_hold_o(eh2), .id_ex_flush_o(ef2), .halt_ack_o(ha2)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .ADDR_W(32)) dut3 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i), .halt_req_i(halt_req_i), .step_i(step_i),
    .jump_en_o(je3), .jump_addr_o(ja3), .pc_hold_o(ph3), .if_id_hold_o(ih3),
    .if_id_flush_o(if3), .id_ex_hold_o(eh3), .id_ex_flush_o(ef3), .halt_ack_o(ha3)
  );

  // Vector order: {jump_en, pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, halt_ack}
  logic [6:0] o2, o3;
  assign o2 = {je2, ph2, ih2, if2, eh2, ef2, ha2};
  assign o3 = {je3, ph3, ih3, if3, eh3, ef3, ha3};

  localparam logic [6:0] Z  = 7'b000_0000;  // idle
  localparam logic [6:0] FL = 7'b000_1010;  // both flushes
  localparam logic [6:0] JF = 7'b100_1010;  // jump + both flushes
  localparam logic [6:0] HX = 7'b011_0100;  // all holds
  localparam logic [6:0] BU = 7'b010_1000;  // bus wait: pc hold + if_id bubble
  localparam logic [6:0] HA = 7'b011_0101;  // halted: holds + ack
  localparam logic [6:0] RA = 7'b000_1011;  // reset while ack still registered

  typedef struct {
    string       tag;
    logic [6:0]  e2;
    logic [6:0]  e3;
    logic [31:0] ea;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cyc(input string tag, input logic r, input logic je, input logic hex,
                     input logic hb, input logic hr, input logic st, input logic [31:0] ja,
                     input logic [6:0] e2, input logic [6:0] e3);
    exp_t e;
    rst         = r;
    jump_en_i   = je;
    hold_ex_i   = hex;
    hold_bus_i  = hb;
    halt_req_i  = hr;
    step_i      = st;
    jump_addr_i = ja;
    exp_q.push_back('{tag, e2, e3, ja});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    assert (o2 === e.e2) else begin
      errors++;
      $error("FAIL %s fc2: got %b want %b", e.tag, o2, e.e2);
    end
    checks++;
    assert (o3 === e.e3) else begin
      errors++;
      $error("FAIL %s fc3: got %b want %b", e.tag, o3, e.e3);
    end
    checks++;
    assert (ja2 === e.ea && ja3 === e.ea) else begin
      errors++;
      $error("FAIL %s addr: got %h/%h want %h", e.tag, ja2, ja3, e.ea);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset
    for (int i = 0; i < 3; i++) cyc("rst", 1, 0, 0, 0, 0, 0, 32'h0, FL, FL);
    cyc("post_rst", 0, 0, 0, 0, 0, 0, 32'h0, Z, Z);

    // 2. jump with multi-cycle flush
    cyc("jmp_c0", 0, 1, 0, 0, 0, 0, 32'h100, JF, JF);
    cyc("jmp_c1", 0, 0, 0, 0, 0, 0, 32'h0, FL, FL);
    cyc("jmp_c2", 0, 0, 0, 0, 0, 0, 32'h0, Z, FL);
    cyc("jmp_c3", 0, 0, 0, 0, 0, 0, 32'h0, Z, Z);

    // 2b. jump inside FLUSH is ignored
    cyc("jif_c0", 0, 1, 0, 0, 0, 0, 32'h180, JF, JF);
    cyc("jif_c1", 0, 1, 0, 0, 0, 0, 32'h184, FL, FL);
    cyc("jif_c2", 0, 0, 0, 0, 0, 0, 32'h0, Z, FL);
    cyc("jif_c3", 0, 0, 0, 0, 0, 0, 32'h0, Z, Z);

    // 3. hold_ex masks a concurrent jump until it drops
    for (int i = 0; i < 3; i++) cyc("hold_ex", 0, 1, 1, 0, 0, 0, 32'h40, HX, HX);
    cyc("hold_rel", 0, 1, 0, 0, 0, 0, 32'h40, JF, JF);
    cyc("hold_f1", 0, 0, 0, 0, 0, 0, 32'h0, FL, FL);
    cyc("hold_f2", 0, 0, 0, 0, 0, 0, 32'h0, Z, FL);
    cyc("hold_f3", 0, 0, 0, 0, 0, 0, 32'h0, Z, Z);

    // 4. fetch-bus wait
    cyc("bus", 0, 0, 0, 1, 0, 0, 32'h0, BU, BU);
    cyc("bus_end", 0, 0, 0, 0, 0, 0, 32'h0, Z, Z);

    // 5. halt, single step, release
    cyc("halt_req", 0, 0, 0, 0, 1, 0, 32'h0, Z, Z);
    cyc("halted", 0, 0, 0, 0, 1, 0, 32'h0, HA, HA);
    cyc("step_in", 0, 0, 0, 0, 1, 1, 32'h0, HA, HA);
    cyc("step", 0, 0, 0, 0, 1, 0, 32'h0, Z, Z);
    cyc("re_halt", 0, 0, 0, 0, 1, 0, 32'h0, HA, HA);
    cyc("release", 0, 0, 0, 0, 0, 0, 32'h0, HA, HA);
    cyc("run_again", 0, 0, 0, 0, 0, 0, 32'h0, Z, Z);

    // 5b. hold_ex during STEP keeps STEP until it clears
    cyc("h2_req", 0, 0, 0, 0, 1, 0, 32'h0, Z, Z);
    cyc("h2_step", 0, 0, 0, 0, 1, 1, 32'h0, HA, HA);
    cyc("step_hx", 0, 0, 1, 0, 1, 0, 32'h0, HX, HX);
    cyc("step_go", 0, 0, 0, 0, 1, 0, 32'h0, Z, Z);
    cyc("h2_halt", 0, 0, 0, 0, 1, 0, 32'h0, HA, HA);

    // 5c. step and halt_req falling together: RUN wins
    cyc("fall_both", 0, 0, 0, 0, 0, 1, 32'h0, HA, HA);
    cyc("fall_run", 0, 0, 0, 0, 0, 0, 32'h0, Z, Z);

    // 6. halt with jump: flush first, then halt; reset out of HALTED
    cyc("hj_c0", 0, 1, 0, 0, 1, 0, 32'h200, JF, JF);
    cyc("hj_c1", 0, 0, 0, 0, 1, 0, 32'h0, FL, FL);
    cyc("hj_c2", 0, 0, 0, 0, 1, 0, 32'h0, HA, FL);
    cyc("hj_c3", 0, 0, 0, 0, 1, 0, 32'h0, HA, HA);
    cyc("hj_rst", 1, 0, 0, 0, 1, 0, 32'h0, RA, RA);
    cyc("hj_after", 0, 0, 0, 0, 0, 0, 32'h0, Z, Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
